// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART frame packer.
package uart_pkg;

  localparam logic [7:0] DEF_HEAD_BYTE = 8'hAA;
  localparam logic [7:0] DEF_TAIL_BYTE = 8'h55;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_LOAD,
    ST_WAIT_ACK,
    ST_WAIT_IDLE,
    ST_NEXT,
    ST_TAIL,
    ST_DONE
  } state_t;

  // Which kind of byte is currently in flight; decides the NEXT transition.
  typedef enum logic [1:0] {
    KIND_HEAD,
    KIND_DATA,
    KIND_TAIL
  } kind_t;

  // Per-frame options captured at sample acceptance.
  typedef struct packed {
    logic head;
    logic tail;
    logic zsub;
  } frame_opt_t;

endpackage

// File: rtl/uart_ack_timer.sv
// Acknowledge timeout: load arms it, each tick counts one waiting cycle,
// expired rises once ACK_TO waiting cycles (including the current one) have elapsed.
module uart_ack_timer #(
  parameter int unsigned ACK_TO = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CNT_W = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (load) begin
      cnt     <= CNT_W'(ACK_TO - 1);
      expired <= (ACK_TO <= 1);
    end else if (tick && (cnt != '0)) begin
      cnt     <= cnt - CNT_W'(1);
      expired <= (cnt == CNT_W'(1));
    end
  end

endmodule

// File: rtl/uart_frame_packer.sv
// Packs a sample word into an optional-header/tail byte frame and feeds it
// one byte at a time to a UART transmitter using a load/busy handshake.
module uart_frame_packer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NBYTES    = 3,
  parameter logic [7:0]  HEAD_BYTE = DEF_HEAD_BYTE,
  parameter logic [7:0]  TAIL_BYTE = DEF_TAIL_BYTE,
  parameter int unsigned ACK_TO    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              head_req,
  input  logic              tail_req,
  input  logic              zsub_en,
  output logic [7:0]        tx_data,
  output logic              tx_load,
  input  logic              tx_busy,
  output logic              send_done,
  output logic              ack_err
);

  localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t            state, state_d;
  kind_t             kind, kind_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  frame_opt_t        opt_q, opt_d;
  logic              ack_err_d;
  logic [7:0]        tx_data_d;
  logic              tx_load_d;
  logic              send_done_d;
  logic              sample_ready_d;
  logic              timer_load_c;
  logic              timer_tick_c;
  logic              timer_expired;

  // Data byte k (MSB-first) with optional zero substitution applied.
  function automatic logic [7:0] data_byte(input logic [DATA_W-1:0] d,
                                           input logic [IDX_W-1:0]  i,
                                           input logic              z);
    logic [DATA_W-1:0] sh;
    logic [7:0]        b;
    sh = d << (32'(i) * 32'd8);
    b  = sh[DATA_W-1 -: 8];
    if (z) begin
      if (d[DATA_W-1:8] == '0) begin
        b = 8'hFF;
      end else if ((i == IDX_W'(NBYTES - 1)) && (b == 8'h00)) begin
        b = 8'h01;
      end
    end
    return b;
  endfunction

  uart_ack_timer #(
    .ACK_TO (ACK_TO)
  ) u_ack_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (timer_load_c),
    .tick    (timer_tick_c),
    .expired (timer_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      kind         <= KIND_DATA;
      idx          <= '0;
      data_q       <= '0;
      opt_q        <= '0;
      ack_err      <= 1'b0;
      tx_data      <= 8'h00;
      tx_load      <= 1'b0;
      send_done    <= 1'b0;
      sample_ready <= 1'b1;
    end else begin
      state        <= state_d;
      kind         <= kind_d;
      idx          <= idx_d;
      data_q       <= data_d;
      opt_q        <= opt_d;
      ack_err      <= ack_err_d;
      tx_data      <= tx_data_d;
      tx_load      <= tx_load_d;
      send_done    <= send_done_d;
      sample_ready <= sample_ready_d;
    end
  end

  always_comb begin
    state_d      = state;
    kind_d       = kind;
    idx_d        = idx;
    data_d       = data_q;
    opt_d        = opt_q;
    ack_err_d    = ack_err;
    timer_load_c = 1'b0;
    timer_tick_c = 1'b0;

    case (state)
      ST_IDLE: begin
        if (sample_valid && sample_ready) begin
          data_d  = sample_data;
          opt_d   = '{head: head_req, tail: tail_req, zsub: zsub_en};
          idx_d   = '0;
          state_d = head_req ? ST_HEAD : ST_LOAD;
        end
      end
      ST_HEAD: begin
        kind_d       = KIND_HEAD;
        timer_load_c = 1'b1;
        state_d      = ST_WAIT_ACK;
      end
      ST_LOAD: begin
        kind_d       = KIND_DATA;
        timer_load_c = 1'b1;
        state_d      = ST_WAIT_ACK;
      end
      ST_TAIL: begin
        kind_d       = KIND_TAIL;
        timer_load_c = 1'b1;
        state_d      = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // A busy already asserted on entry is taken as the acknowledge.
        if (tx_busy) begin
          state_d = ST_WAIT_IDLE;
        end else if (timer_expired) begin
          ack_err_d = 1'b1;
          state_d   = ST_WAIT_IDLE;
        end else begin
          timer_tick_c = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (!tx_busy) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        case (kind)
          KIND_HEAD: begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end
          KIND_DATA: begin
            if (idx < IDX_W'(NBYTES - 1)) begin
              idx_d   = idx + IDX_W'(1);
              state_d = ST_LOAD;
            end else begin
              state_d = opt_q.tail ? ST_TAIL : ST_DONE;
            end
          end
          default: state_d = ST_DONE;
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state presents.
  always_comb begin
    tx_data_d      = tx_data;
    tx_load_d      = 1'b0;
    send_done_d    = (state_d == ST_DONE);
    sample_ready_d = (state_d == ST_IDLE);
    case (state_d)
      ST_HEAD: begin
        tx_data_d = HEAD_BYTE;
        tx_load_d = 1'b1;
      end
      ST_LOAD: begin
        tx_data_d = data_byte(data_d, idx_d, opt_d.zsub);
        tx_load_d = 1'b1;
      end
      ST_TAIL: begin
        tx_data_d = TAIL_BYTE;
        tx_load_d = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/uart_frame_packer.md
UART_FRAME_PACKER -- requirements
Module: uart_frame_packer

Interface
REQ-001 Parameter DATA_W, default 32: sample word width in bits; multiple of 8, 16..64.
REQ-002 Parameter NBYTES, default 3: bytes sent per sample, taken MSB-first from sample_data; 1..DATA_W/8.
REQ-003 Parameter HEAD_BYTE, default 8'hAA: frame header byte.
REQ-004 Parameter TAIL_BYTE, default 8'h55: frame tail byte.
REQ-005 Parameter ACK_TO, default 16: cycles to wait for tx_busy to assert after a load.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 sample_valid  input  1  sample_data is valid this cycle.
REQ-009 sample_ready  output  1  packer accepts a sample this cycle.
REQ-010 sample_data  input  DATA_W  sample word.
REQ-011 head_req  input  1  prefix HEAD_BYTE to this sample; sampled at acceptance.
REQ-012 tail_req  input  1  append TAIL_BYTE after this sample; sampled at acceptance.
REQ-013 zsub_en  input  1  enables zero substitution; sampled at acceptance.
REQ-014 tx_data  output  8  byte presented to the UART transmitter.
REQ-015 tx_load  output  1  one-cycle load strobe to the transmitter.
REQ-016 tx_busy  input  1  transmitter is shifting a byte.
REQ-017 send_done  output  1  one-cycle pulse after the last byte of a frame completes.
REQ-018 ack_err  output  1  sticky flag: tx_busy timeout occurred.

Function
REQ-019 States: IDLE, HEAD, LOAD, WAIT_ACK, WAIT_IDLE, NEXT, TAIL, DONE.
REQ-020 Handshake: a sample is accepted when sample_valid and sample_ready are both high.
REQ-021 sample_ready is high only in IDLE.
REQ-022 On acceptance, the packer latches sample_data, head_req, tail_req and zsub_en; the byte index clears to 0.
REQ-023 Next state after acceptance: HEAD if head_req, else LOAD.
REQ-024 HEAD: tx_data=HEAD_BYTE with tx_load=1 for exactly one cycle, then WAIT_ACK.
REQ-025 LOAD: tx_data = byte[idx] with tx_load=1 for one cycle, then WAIT_ACK.
REQ-026 byte[k] = latched bits [DATA_W-1-8k -: 8].
REQ-027 tx_data holds its value from the load cycle until the next load.
REQ-028 WAIT_ACK exits to WAIT_IDLE when tx_busy=1.
REQ-029 WAIT_ACK times out after ACK_TO cycles without tx_busy: set ack_err and go to WAIT_IDLE.
REQ-030 WAIT_IDLE exits to NEXT when tx_busy=0.
REQ-031 NEXT, header just sent: go to LOAD with idx=0.
REQ-032 NEXT, idx<NBYTES-1: increment idx, go to LOAD.
REQ-033 NEXT, idx=NBYTES-1: go to TAIL if tail_req latched, else DONE.
REQ-034 NEXT, tail just sent: go to DONE.
REQ-035 TAIL: tx_data=TAIL_BYTE with tx_load=1 for one cycle, then WAIT_ACK.
REQ-036 DONE: send_done=1 for one cycle, then IDLE.
REQ-037 Zero substitution applies only when zsub_en is latched 1 and affects data bytes only.
REQ-038 Zero substitution: if latched bits [DATA_W-1:8] are all zero, every data byte is sent as 8'hFF.
REQ-039 Zero substitution otherwise: if the last data byte would be 8'h00, it is sent as 8'h01.
REQ-040 Frame length is NBYTES + head_req + tail_req bytes; the idx counter never wraps.
REQ-041 sample_valid outside IDLE is ignored and never lost-accepted.
REQ-042 tx_busy already high at entry to WAIT_ACK counts as the acknowledge.
REQ-043 ack_err clears only on reset.

Reset
REQ-044 Reset applies on the clock edge regardless of state, aborting any frame in progress with no send_done.
REQ-045 Reset state: state=IDLE, idx=0, tx_data=8'h00, tx_load=0, send_done=0, ack_err=0.
REQ-046 sample_ready is 1 in the first cycle after reset is released.

Structure
REQ-047 State encoding and the default HEAD_BYTE/TAIL_BYTE values are defined in shared package uart_pkg.
REQ-048 The timeout counter is a sub-module, uart_ack_timer (load, tick, expired).

Verification
REQ-049 DATA_W=32, NBYTES=3, no head/tail, sample 32'h12345678, tx_busy 10 cycles per byte -> bytes 12,34,56; one send_done.
REQ-050 head_req=1, tail_req=1, sample 32'hA1B2C3D4 -> bytes AA,A1,B2,C3,55.
REQ-051 zsub_en=1, sample 32'h000000FF -> bytes FF,FF,FF; sample 32'h0F000000 -> bytes 0F,00,01.
REQ-052 tx_busy held low -> ack_err=1 after ACK_TO cycles; frame still completes; send_done pulses.
REQ-053 Reset asserted during the second byte -> next cycle IDLE, tx_load=0, no send_done, sample_ready=1.
REQ-054 sample_valid held high continuously -> back-to-back frames; each sample accepted exactly once.
